norz_phase_sequencer: RTL and testbench

//  Sequential front end for the I-decoder tree: owns ITABLE (latched opcode) and XPT (execution phase).

---
 rtl/norz_dec_pkg.sv | 34 +++
 rtl/norz_prefix_detect.sv | 31 +++
 rtl/norz_phase_sequencer.sv | 160 ++++++++++++++++
 tb/tb_norz_phase_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/norz_dec_pkg.sv
// ----------------------------------------------------------------------------
// norz_dec_pkg
//   Shared definitions for the I-decoder front end: sequencer state encoding,
//   prefix codes reported on the prefix bus, and the opcode constants that the
//   prefix detector and interrupt-acknowledge path compare against.
//   Optional feature macro: NORZ_INT_ACK_EN (adds the INTACK state).
// ----------------------------------------------------------------------------
package norz_dec_pkg;

`ifdef NORZ_INT_ACK_EN
   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_EXEC   = 2'd1,
      ST_INTACK = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_EXEC   = 2'd1
   } state_t;
`endif

   localparam logic [1:0] PFX_NONE = 2'd0;
   localparam logic [1:0] PFX_CB   = 2'd1;
   localparam logic [1:0] PFX_DDED = 2'd2;
   localparam logic [1:0] PFX_FD   = 2'd3;

   localparam logic [7:0] OP_CB = 8'hCB;
   localparam logic [7:0] OP_DD = 8'hDD;
   localparam logic [7:0] OP_ED = 8'hED;
   localparam logic [7:0] OP_FD = 8'hFD;
   localparam logic [7:0] OP_FF = 8'hFF;   // RST 38h, forced during INTACK

endpackage

// File: rtl/norz_prefix_detect.sv
// ----------------------------------------------------------------------------
// norz_prefix_detect
//   Combinational classifier for a fetched byte.
//   Ports:
//     op        in  W   fetched byte
//     is_prefix out 1   byte is CB, DD, ED or FD
//     code      out 2   prefix code (1 CB, 2 DD/ED, 3 FD, 0 otherwise)
// ----------------------------------------------------------------------------
module norz_prefix_detect
   import norz_dec_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] op,
   output logic         is_prefix,
   output logic [1:0]   code
);

   always_comb begin
      is_prefix = 1'b0;
      code      = PFX_NONE;
      case (op)
         W'(OP_CB): begin is_prefix = 1'b1; code = PFX_CB;   end
         W'(OP_DD): begin is_prefix = 1'b1; code = PFX_DDED; end
         W'(OP_ED): begin is_prefix = 1'b1; code = PFX_DDED; end
         W'(OP_FD): begin is_prefix = 1'b1; code = PFX_FD;   end
         default:   begin is_prefix = 1'b0; code = PFX_NONE; end
      endcase
   end

endmodule

// File: rtl/norz_phase_sequencer.sv
// ----------------------------------------------------------------------------
// norz_phase_sequencer
//   Sequential front end of the I-decoder tree. Holds the latched opcode
//   (ITABLE) and the execution phase counter (XPT), absorbs up to MAX_PREFIX
//   prefix bytes, and steps XPT while the decoder drives control pulses.
//   Optional feature macro: NORZ_INT_ACK_EN (int_req/int_ack, INTACK state).
//   Ports:
//     clock, reset        clock and synchronous active-high reset
//     op_valid, op_in     fetched byte handshake
//     mem_wait            freezes every register
//     PR_Reset_XPT        decoder: clear XPT
//     P2_Set_CM1          decoder: end of instruction, back to fetch
//     P2_Reset_ITABLE     decoder: with CM1, clear ITABLE and prefix
//     op_req              high while fetching
//     dec_enable          high while executing
//     XPT/notXPT          phase counter and complement
//     ITABLE/notITABLE    latched opcode and complement
//     prefix              last prefix byte seen
//     xpt_overflow        one-cycle pulse when XPT wraps without CM1
//     int_req/int_ack     (macro only) interrupt request / acknowledge
// ----------------------------------------------------------------------------
module norz_phase_sequencer
   import norz_dec_pkg::*;
#(
   parameter int XPT_W      = 4,
   parameter int ITABLE_W   = 8,
   parameter int MAX_PREFIX = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                op_valid,
   input  logic [ITABLE_W-1:0] op_in,
   input  logic                mem_wait,
   input  logic                PR_Reset_XPT,
   input  logic                P2_Set_CM1,
   input  logic                P2_Reset_ITABLE,
`ifdef NORZ_INT_ACK_EN
   input  logic                int_req,
   output logic                int_ack,
`endif
   output logic                op_req,
   output logic                dec_enable,
   output logic [XPT_W-1:0]    XPT,
   output logic [XPT_W-1:0]    notXPT,
   output logic [ITABLE_W-1:0] ITABLE,
   output logic [ITABLE_W-1:0] notITABLE,
   output logic [1:0]          prefix,
   output logic                xpt_overflow
);

   localparam int CNT_W = $clog2(MAX_PREFIX + 2);

   state_t            state, state_next;
   logic [CNT_W-1:0]  prefix_cnt;
   logic              is_prefix;
   logic [1:0]        pfx_code;

   logic accept, absorb, latch_op, run, cm1, rst_xpt, inc, wrap;

   norz_prefix_detect #(.W(ITABLE_W)) u_detect (
      .op        (op_in),
      .is_prefix (is_prefix),
      .code      (pfx_code)
   );

   // Per-cycle events; mem_wait suppresses all of them so every register holds.
   always_comb begin
      accept   = (state == ST_FETCH) && op_valid && !mem_wait;
      absorb   = accept && is_prefix && (prefix_cnt < CNT_W'(MAX_PREFIX));
      latch_op = accept && !absorb;
      run      = (state == ST_EXEC) && !mem_wait;
      cm1      = run && P2_Set_CM1;
      rst_xpt  = run && !P2_Set_CM1 && PR_Reset_XPT;
      inc      = run && !P2_Set_CM1 && !PR_Reset_XPT;
      wrap     = inc && (XPT == '1);
   end

`ifdef NORZ_INT_ACK_EN
   // Interrupt is taken only at an instruction boundary with no prefix left over.
   logic to_intack, intack_run;
   always_comb begin
      to_intack  = cm1 && int_req && ((prefix == PFX_NONE) || P2_Reset_ITABLE);
      intack_run = (state == ST_INTACK) && !mem_wait;
   end
`endif

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= ST_FETCH;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_FETCH: if (latch_op) state_next = ST_EXEC;
         ST_EXEC: begin
`ifdef NORZ_INT_ACK_EN
            if (to_intack)  state_next = ST_INTACK;
            else if (cm1 || wrap) state_next = ST_FETCH;
`else
            if (cm1 || wrap) state_next = ST_FETCH;
`endif
         end
`ifdef NORZ_INT_ACK_EN
         ST_INTACK: if (!mem_wait) state_next = ST_EXEC;
`endif
         default: state_next = ST_FETCH;
      endcase
   end

   // Output decode
   always_comb begin
      op_req     = (state == ST_FETCH);
      dec_enable = (state == ST_EXEC);
`ifdef NORZ_INT_ACK_EN
      int_ack    = (state == ST_INTACK);
`endif
   end

   // Datapath registers: phase counter, opcode latch, prefix record.
   always_ff @(posedge clock) begin
      if (reset) begin
         XPT          <= '0;
         ITABLE       <= '0;
         prefix       <= PFX_NONE;
         prefix_cnt   <= '0;
         xpt_overflow <= 1'b0;
      end else begin
         // Pulse, not a held flag: drops on the cycle after the wrap.
         xpt_overflow <= wrap;
         // A prefix byte forced through as an opcode is still recorded.
         if (accept && is_prefix) prefix <= pfx_code;
         if (absorb) prefix_cnt <= prefix_cnt + 1'b1;
         if (latch_op) begin
            ITABLE     <= op_in;
            XPT        <= '0;
            prefix_cnt <= '0;
         end
         if (cm1 || rst_xpt) XPT <= '0;
         if (inc) XPT <= XPT + 1'b1;   // natural modulo wrap gives 0 on overflow
         if (cm1 && P2_Reset_ITABLE) begin
            ITABLE <= '0;
            prefix <= PFX_NONE;
         end
`ifdef NORZ_INT_ACK_EN
         if (intack_run) begin
            ITABLE <= ITABLE_W'(OP_FF);
            XPT    <= '0;
         end
`endif
      end
   end

   // Complements come straight off the registered values.
   assign notXPT    = ~XPT;
   assign notITABLE = ~ITABLE;

endmodule

// File: tb/tb_norz_phase_sequencer.sv
module tb_norz_phase_sequencer;

   logic       clock = 1'b0;
   logic       reset, op_valid, mem_wait, PR_Reset_XPT, P2_Set_CM1, P2_Reset_ITABLE;
   logic [7:0] op_in;
   logic       op_req, dec_enable, xpt_overflow;
   logic [3:0] XPT, notXPT;
   logic [7:0] ITABLE, notITABLE;
   logic [1:0] prefix;
`ifdef NORZ_INT_ACK_EN
   logic       int_req = 1'b0;
   logic       int_ack;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state (plain integers)
   int m_mode;    // 0 fetch, 1 exec
   int m_xpt, m_itab, m_pfx, m_cnt, m_ovf;

   always #5 clock = ~clock;

   norz_phase_sequencer #(.XPT_W(4), .ITABLE_W(8), .MAX_PREFIX(2)) dut (
      .clock           (clock),
      .reset           (reset),
      .op_valid        (op_valid),
      .op_in           (op_in),
      .mem_wait        (mem_wait),
      .PR_Reset_XPT    (PR_Reset_XPT),
      .P2_Set_CM1      (P2_Set_CM1),
      .P2_Reset_ITABLE (P2_Reset_ITABLE),
`ifdef NORZ_INT_ACK_EN
      .int_req         (int_req),
      .int_ack         (int_ack),
`endif
      .op_req          (op_req),
      .dec_enable      (dec_enable),
      .XPT             (XPT),
      .notXPT          (notXPT),
      .ITABLE          (ITABLE),
      .notITABLE       (notITABLE),
      .prefix          (prefix),
      .xpt_overflow    (xpt_overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int prefix_code(input int b);
      if (b == 'hCB) return 1;
      if (b == 'hDD || b == 'hED) return 2;
      if (b == 'hFD) return 3;
      return 0;
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      int nxt_ovf;
      int code;
      nxt_ovf = 0;
      if (reset) begin
         m_mode = 0; m_xpt = 0; m_itab = 0; m_pfx = 0; m_cnt = 0; m_ovf = 0;
         return;
      end
      if (mem_wait) begin
         m_ovf = 0;
         return;
      end
      if (m_mode == 0) begin
         if (op_valid) begin
            code = prefix_code(int'(op_in));
            if (code != 0) m_pfx = code;
            if (code != 0 && m_cnt < 2) m_cnt = m_cnt + 1;
            else begin
               m_itab = int'(op_in); m_xpt = 0; m_cnt = 0; m_mode = 1;
            end
         end
      end else begin
         if (P2_Set_CM1) begin
            m_mode = 0; m_xpt = 0;
            if (P2_Reset_ITABLE) begin m_itab = 0; m_pfx = 0; end
         end else if (PR_Reset_XPT) m_xpt = 0;
         else if (m_xpt == 15) begin
            m_xpt = 0; nxt_ovf = 1; m_mode = 0;
         end else m_xpt = m_xpt + 1;
      end
      m_ovf = nxt_ovf;
   endtask

   task automatic check_all();
      check("op_req",       32'(op_req),       32'(m_mode == 0));
      check("dec_enable",   32'(dec_enable),   32'(m_mode == 1));
      check("XPT",          32'(XPT),          32'(m_xpt));
      check("notXPT",       32'(notXPT),       32'(15 - m_xpt));
      check("ITABLE",       32'(ITABLE),       32'(m_itab));
      check("notITABLE",    32'(notITABLE),    32'(255 - m_itab));
      check("prefix",       32'(prefix),       32'(m_pfx));
      check("xpt_overflow", 32'(xpt_overflow), 32'(m_ovf));
   endtask

   task automatic step(input logic r, input logic mw, input logic ov, input logic [7:0] op,
                       input logic cm, input logic prx, input logic rit);
      reset = r; mem_wait = mw; op_valid = ov; op_in = op;
      P2_Set_CM1 = cm; PR_Reset_XPT = prx; P2_Reset_ITABLE = rit;
      model_step();
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, 0, 0, 0);
   endtask

   initial begin
      m_mode = 0; m_xpt = 0; m_itab = 0; m_pfx = 0; m_cnt = 0; m_ovf = 0;

      // Reset
      step(1, 0, 0, 8'h00, 0, 0, 0);
      step(1, 1, 1, 8'h3E, 1, 1, 1);
      check("reset_notXPT", 32'(notXPT), 32'hF);
      check("reset_op_req", 32'(op_req), 32'd1);

      // Plain opcode, XPT steps, CM1 at XPT=2
      step(0, 0, 1, 8'h3E, 0, 0, 0);
      check("op3e_itable", 32'(ITABLE), 32'h3E);
      check("op3e_xpt0", 32'(XPT), 32'd0);
      idle(2);
      check("op3e_xpt2", 32'(XPT), 32'd2);
      step(0, 0, 0, 8'h00, 1, 0, 0);
      check("cm1_op_req", 32'(op_req), 32'd1);
      check("cm1_xpt", 32'(XPT), 32'd0);

      // Decoder inputs ignored while fetching
      step(0, 0, 0, 8'h00, 1, 1, 1);
      check("fetch_ignores_dec_itable", 32'(ITABLE), 32'h3E);

      // Prefix chain: DD, CB, then DD forced as opcode
      step(0, 0, 1, 8'hDD, 0, 0, 0);
      step(0, 0, 1, 8'hCB, 0, 0, 0);
      check("pfx_cb_still_fetch", 32'(op_req), 32'd1);
      step(0, 0, 1, 8'hDD, 0, 0, 0);
      check("pfx_itable_dd", 32'(ITABLE), 32'hDD);
      check("pfx_code_dd", 32'(prefix), 32'd2);
      check("pfx_exec", 32'(dec_enable), 32'd1);

      // Wrap without CM1
      idle(15);
      check("wrap_xpt15", 32'(XPT), 32'd15);
      idle(1);
      check("wrap_ovf", 32'(xpt_overflow), 32'd1);
      check("wrap_fetch", 32'(op_req), 32'd1);
      idle(1);
      check("wrap_ovf_drop", 32'(xpt_overflow), 32'd0);

      // mem_wait holds XPT=1 despite PR_Reset_XPT
      step(0, 0, 1, 8'h3E, 0, 0, 0);
      idle(1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 0, 1, 0);
      check("wait_xpt_hold", 32'(XPT), 32'd1);
      step(0, 0, 0, 8'h00, 0, 1, 0);
      check("wait_release_xpt", 32'(XPT), 32'd0);

      // op_valid with mem_wait in fetch is not accepted
      step(0, 0, 0, 8'h00, 1, 0, 1);
      step(0, 1, 1, 8'h47, 0, 0, 0);
      check("wait_no_accept", 32'(op_req), 32'd1);

      // Reset mid-EXEC at XPT=5
      step(0, 0, 1, 8'h21, 0, 0, 0);
      idle(5);
      check("mid_exec_xpt5", 32'(XPT), 32'd5);
      step(1, 0, 0, 8'h00, 0, 0, 0);
      check("mid_reset_xpt", 32'(XPT), 32'd0);
      check("mid_reset_itable", 32'(ITABLE), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] b;
         case ($urandom_range(0, 5))
            0: b = 8'hCB;
            1: b = 8'hDD;
            2: b = 8'hED;
            3: b = 8'hFD;
            default: b = 8'($urandom);
         endcase
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 1) == 0), b,
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 1) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
